// File: rtl/shot_clock_pkg.sv
// Shared types for the shot-clock countdown: FSM state encoding and BCD digit helpers.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BLANK_DIGIT = 4'hF;
    localparam bcd_t BCD_ZERO    = 4'd0;
    localparam bcd_t BCD_ONE     = 4'd1;
    localparam bcd_t BCD_NINE    = 4'd9;

endpackage

// File: rtl/shot_clock_counter_tick_gen.sv
// Modulo-DIV free-running divider; pulse is the combinational wrap indication (high while
// the counter sits on DIV-1 and is enabled). clr has priority over en.
module tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = en && (r_cnt == LAST);
    assign pulse  = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shot_clock_counter.sv
// BCD shot-clock countdown feeding sevenseg_mux: FSM, two-digit count, scan strobe.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module shot_clock_counter
    import shot_clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned START_VAL = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       reload,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       scan_en,
    output logic       running,
    output logic       expired,
    output logic       at_zero
);

    localparam bcd_t START_TENS  = 4'((START_VAL / 10) % 10);
    localparam bcd_t START_UNITS = 4'(START_VAL % 10);
    localparam logic START_ZERO  = 1'(START_VAL == 0);

    // Display mapping of the tens digit; the internal count is never blanked.
    function automatic bcd_t disp_tens(input bcd_t tens);
`ifdef LEADING_ZERO_BLANK_EN
        return (tens == BCD_ZERO) ? BLANK_DIGIT : tens;
`else
        return tens;
`endif
    endfunction

    state_t r_state, w_state_nxt;
    bcd_t   r_tens, r_units, w_tens_nxt, w_units_nxt;
    bcd_t   r_d1;
    logic   r_scan_en, r_running, r_expired, r_at_zero;
    logic   w_tick_en, w_tick_clr, w_tick_pulse, w_scan_pulse;
    logic   w_expire, w_is_zero;

    assign w_is_zero = (r_tens == BCD_ZERO) && (r_units == BCD_ZERO);
    assign w_tick_en = (r_state == ST_RUN);

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_tick_en),
        .clr   (w_tick_clr),
        .pulse (w_tick_pulse)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .pulse (w_scan_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pulse priority reload > stop > start; a step to 00 overrides a same-cycle stop.
    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_units_nxt = r_units;
        w_tick_clr  = 1'b0;
        w_expire    = 1'b0;
        if (reload) begin
            w_state_nxt = ST_IDLE;
            w_tens_nxt  = START_TENS;
            w_units_nxt = START_UNITS;
            w_tick_clr  = 1'b1;
        end else begin
            if ((r_state == ST_RUN) && w_tick_pulse && !w_is_zero) begin
                if (r_units != BCD_ZERO) begin
                    w_units_nxt = r_units - 4'd1;
                end else begin
                    w_units_nxt = BCD_NINE;
                    w_tens_nxt  = r_tens - 4'd1;
                end
                if ((r_tens == BCD_ZERO) && (r_units == BCD_ONE)) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_EXPIRED;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop && !w_is_zero) begin
                        w_state_nxt = ST_RUN;
                        w_tick_clr  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop && !w_expire) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens    <= START_TENS;
            r_units   <= START_UNITS;
            r_d1      <= disp_tens(START_TENS);
            r_scan_en <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_at_zero <= START_ZERO;
        end else begin
            r_tens    <= w_tens_nxt;
            r_units   <= w_units_nxt;
            r_d1      <= disp_tens(w_tens_nxt);
            r_scan_en <= w_scan_pulse;
            r_running <= (w_state_nxt == ST_RUN);
            r_expired <= w_expire;
            r_at_zero <= (w_tens_nxt == BCD_ZERO) && (w_units_nxt == BCD_ZERO);
        end
    end

    assign d3      = BLANK_DIGIT;
    assign d2      = BLANK_DIGIT;
    assign d1      = r_d1;
    assign d0      = r_units;
    assign scan_en = r_scan_en;
    assign running = r_running;
    assign expired = r_expired;
    assign at_zero = r_at_zero;

endmodule

// File: tb/tb_shot_clock_counter.sv
// Bench for shot_clock_counter: decimal-count reference model checked every cycle plus
// hand-computed directed checks. Honours LEADING_ZERO_BLANK_EN for tens-digit expectations.
module tb_shot_clock_counter;

    localparam int unsigned TICK_DIV  = 8;
    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned START_VAL = 12;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, reload = 1'b0;
    logic [3:0] d3, d2, d1, d0;
    logic       scan_en, running, expired, at_zero;

    int n_checks = 0;
    int n_errors = 0;
    int n_exp_pulses = 0;
    bit m_chk = 1'b0;

    // Reference model: decimal count, elapsed run clocks since last step, edges since reset.
    int m_count, m_frac, m_edges, m_mode;
    bit m_exp, m_scan;

    shot_clock_counter #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .START_VAL(START_VAL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .reload (reload),
        .d3     (d3),
        .d2     (d2),
        .d1     (d1),
        .d0     (d0),
        .scan_en(scan_en),
        .running(running),
        .expired(expired),
        .at_zero(at_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [3:0] tb_d1(input int tens);
`ifdef LEADING_ZERO_BLANK_EN
        return (tens == 0) ? 4'hF : 4'(tens);
`else
        return 4'(tens);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = START_VAL;
            m_frac  = 0;
            m_edges = 0;
            m_mode  = M_IDLE;
            m_exp   = 1'b0;
            m_scan  = 1'b0;
        end else begin
            m_edges++;
            m_scan = ((m_edges % SCAN_DIV) == 0);
            m_exp  = 1'b0;
            if (reload) begin
                m_mode  = M_IDLE;
                m_count = START_VAL;
                m_frac  = 0;
            end else begin
                if (m_mode == M_RUN) begin
                    m_frac++;
                    if (m_frac == TICK_DIV) begin
                        m_frac = 0;
                        m_count--;
                        if (m_count == 0) begin
                            m_mode = M_EXP;
                            m_exp  = 1'b1;
                        end
                    end
                end
                if (stop) begin
                    if (m_mode == M_RUN) m_mode = M_PAUSE;
                end else if (start) begin
                    if (m_mode == M_IDLE && m_count != 0) begin
                        m_mode = M_RUN;
                        m_frac = 0;
                    end else if (m_mode == M_PAUSE) begin
                        m_mode = M_RUN;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [19:0] want_v;
        if (m_chk) begin
            want_v = {4'hF, 4'hF, tb_d1(m_count / 10), 4'(m_count % 10),
                      m_scan, (m_mode == M_RUN), m_exp, (m_count == 0)};
            chk("model", 32'({d3, d2, d1, d0, scan_en, running, expired, at_zero}), 32'(want_v));
            if (expired) n_exp_pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        m_chk = 1'b1;

        // Reset values and first scan strobe
        step(3);
        chk("rst_d3", 32'(d3), 32'hF);
        chk("rst_d2", 32'(d2), 32'hF);
        chk("rst_d1", 32'(d1), 32'(tb_d1(1)));
        chk("rst_d0", 32'(d0), 32'd2);
        chk("rst_running", 32'(running), 32'd0);
        chk("scan_pre", 32'(scan_en), 32'd0);
        step(1);
        chk("scan_first", 32'(scan_en), 32'd1);
        step(1);
        chk("scan_after", 32'(scan_en), 32'd0);

        // Full countdown to expiry
        start = 1'b1; step(1); start = 1'b0;
        chk("run_start", 32'(running), 32'd1);
        step(23);
        chk("ten_d1", 32'(d1), 32'(tb_d1(1)));
        chk("ten_d0", 32'(d0), 32'd0);
        step(1);
        chk("nine_d1", 32'(d1), 32'(tb_d1(0)));
        chk("nine_d0", 32'(d0), 32'd9);
        step(72);
        chk("zero_d0", 32'(d0), 32'd0);
        chk("zero_expired", 32'(expired), 32'd1);
        chk("zero_at_zero", 32'(at_zero), 32'd1);
        chk("zero_running", 32'(running), 32'd0);
        step(1);
        chk("expired_once", 32'(expired), 32'd0);

        // EXPIRED ignores start/stop; reload restores
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        chk("exp_start_ign", 32'(running), 32'd0);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("exp_stop_ign", 32'(at_zero), 32'd1);
        reload = 1'b1; step(1); reload = 1'b0;
        chk("reload_d1", 32'(d1), 32'(tb_d1(1)));
        chk("reload_d0", 32'(d0), 32'd2);
        chk("reload_at_zero", 32'(at_zero), 32'd0);
        chk("reload_expired", 32'(expired), 32'd0);
        step(10);
        chk("idle_hold", 32'(d0), 32'd2);

        // Reload on the tick-wrap cycle wins
        start = 1'b1; step(1); start = 1'b0;
        step(7);
        reload = 1'b1; step(1); reload = 1'b0;
        chk("wrap_reload_d0", 32'(d0), 32'd2);
        chk("wrap_reload_run", 32'(running), 32'd0);

        // Pause keeps partial tick
        start = 1'b1; step(1); start = 1'b0;
        step(19);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("pause_running", 32'(running), 32'd0);
        chk("pause_d0", 32'(d0), 32'd0);
        step(50);
        chk("pause_hold_d1", 32'(d1), 32'(tb_d1(1)));
        chk("pause_hold_d0", 32'(d0), 32'd0);
        start = 1'b1; step(1); start = 1'b0;
        chk("resume_running", 32'(running), 32'd1);
        step(3);
        chk("resume_pre", 32'(d0), 32'd0);
        step(1);
        chk("resume_step", 32'(d0), 32'd9);

        // Tens digit display at 05 and 00
        step(32);
        chk("five_d1", 32'(d1), 32'(tb_d1(0)));
        chk("five_d0", 32'(d0), 32'd5);
        step(40);
        chk("zero2_d1", 32'(d1), 32'(tb_d1(0)));
        chk("zero2_d0", 32'(d0), 32'd0);
        chk("zero2_expired", 32'(expired), 32'd1);

        // Simultaneous pulses
        reload = 1'b1; step(1); reload = 1'b0;
        start = 1'b1; step(1); start = 1'b0;
        step(5);
        start = 1'b1; stop = 1'b1; reload = 1'b1; step(1);
        start = 1'b0; stop = 1'b0; reload = 1'b0;
        chk("all3_running", 32'(running), 32'd0);
        chk("all3_d0", 32'(d0), 32'd2);
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        start = 1'b1; stop = 1'b1; step(1);
        start = 1'b0; stop = 1'b0;
        chk("stopstart_pause", 32'(running), 32'd0);
        step(2);
        start = 1'b1; step(1); start = 1'b0;
        chk("stopstart_resume", 32'(running), 32'd1);

        // Asynchronous reset mid-run
        step(10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_d1", 32'(d1), 32'(tb_d1(1)));
        chk("arst_d0", 32'(d0), 32'd2);
        chk("arst_scan", 32'(scan_en), 32'd0);
        step(2);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(6);

        chk("expired_pulses", 32'(n_exp_pulses), 32'd2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
